// File: rtl/sram_pkg.sv
// sram_pkg: shared types and elaboration checks for the sram_ctrl block.
// Holds the controller state type, legal read-latency range and a config check.
package sram_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit cfg_ok(
    input int data_w,
    input int depth,
    input int addr_w,
    input int rd_lat
  );
    bit ok;
    ok = (data_w > 0) && (data_w % 8 == 0) && (depth > 0);
    ok = ok && (addr_w > 0) && (addr_w < 63);
    ok = ok && ((64'd1 << addr_w) >= 64'(depth));
    ok = ok && (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    return ok;
  endfunction

endpackage

// File: rtl/sram_array.sv
// sram_array: raw single-port storage, byte-enable write, registered read.
// Ports: clk_i, we_i/be_i/wdata_i (write), re_i (read), addr_i, rdata_o.
module sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 262144,
  parameter int IDX_W  = 18
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [IDX_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset here so the array maps straight onto RAM macros.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready SRAM front end with range check, background clear
// and 1- or 2-cycle response latency. Ports: req_* in, rsp_* out, busy.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 262144,
  parameter int ADDR_W         = 18,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;

  if (!cfg_ok(DATA_W, DEPTH, ADDR_W, RD_LAT)) begin : g_bad_cfg
    $error("sram_ctrl: illegal DATA_W/DEPTH/ADDR_W/RD_LAT");
  end

  state_t           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic             ready_q;
  logic             busy_q;

  logic              accept;
  logic              in_range;
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_rdata;

  assign in_range = 64'(req_addr) < 64'(DEPTH);
  assign accept   = req_valid && ready_q;

  // Clear sequencer owns the array port while clearing.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = req_addr[IDX_W-1:0];
    arr_wdata = req_wdata;
    arr_be    = req_be;
    if (rst_n && state_q == CLEAR) begin
      arr_we    = 1'b1;
      arr_addr  = clr_cnt_q;
      arr_wdata = '0;
      arr_be    = '1;
    end else if (rst_n && accept && in_range) begin
      arr_we = req_we;
      arr_re = !req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= (CLEAR_ON_RESET != 0);
    end else begin
      unique case (state_q)
        CLEAR: begin
          ready_q   <= 1'b0;
          busy_q    <= 1'b1;
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q   <= RUN;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic              v1_q;
  logic              err1_q;
  logic              rd1_q;
  logic [DATA_W-1:0] s1_rdata;

  // rd1_q only changes on accept, so the muxed data holds between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      err1_q <= 1'b0;
      rd1_q  <= 1'b0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        err1_q <= !in_range;
        rd1_q  <= !req_we && in_range;
      end
    end
  end

  assign s1_rdata = rd1_q ? arr_rdata : '0;

  if (RD_LAT == 1) begin : g_lat1
    assign rsp_valid = v1_q;
    assign rsp_rdata = s1_rdata;
    assign rsp_err   = err1_q;
  end else begin : g_lat2
    logic              v2_q;
    logic              err2_q;
    logic [DATA_W-1:0] rdata2_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v2_q     <= 1'b0;
        err2_q   <= 1'b0;
        rdata2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          err2_q   <= err1_q;
          rdata2_q <= s1_rdata;
        end
      end
    end

    assign rsp_valid = v2_q;
    assign rsp_rdata = rdata2_q;
    assign rsp_err   = err2_q;
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;

  sram_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .addr_i (arr_addr),
    .wdata_i(arr_wdata),
    .be_i   (arr_be),
    .rdata_o(arr_rdata)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl, RD_LAT 1/2 and no-clear variant.
// Drives shared request inputs into three instances and checks responses.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid12;
  logic        valid3;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rdy1, rv1, re1, bz1;
  logic        rdy2, rv2, re2, bz2;
  logic        rdy3, rv3, re3, bz3;
  logic [31:0] rd1, rd2, rd3;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  vec_t vt[14];
  logic [31:0] model[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .RD_LAT(1),
              .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid12), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1),
    .busy(bz1));

  sram_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .RD_LAT(2),
              .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid12), .req_ready(rdy2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2),
    .busy(bz2));

  sram_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .RD_LAT(1),
              .CLEAR_ON_RESET(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3),
    .busy(bz3));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rv1) begin
      if (q1.size() == 0) begin
        chk("rsp1 unexpected", {31'd0, rv1}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("rsp1 cycle", 32'(cyc), 32'(e1.due));
        chk("rsp1 rdata", rd1, e1.d);
        chk("rsp1 err", {31'd0, re1}, {31'd0, e1.e});
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      chk("rsp1 missing", {31'd0, rv1}, 32'd1);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rv2) begin
      if (q2.size() == 0) begin
        chk("rsp2 unexpected", {31'd0, rv2}, 32'd0);
      end else begin
        e2 = q2.pop_front();
        chk("rsp2 cycle", 32'(cyc), 32'(e2.due));
        chk("rsp2 rdata", rd2, e2.d);
        chk("rsp2 err", {31'd0, re2}, {31'd0, e2.e});
      end
    end else if (q2.size() != 0 && q2[0].due <= cyc) begin
      chk("rsp2 missing", {31'd0, rv2}, 32'd1);
      void'(q2.pop_front());
    end
  end

  // Call just after a rising edge; returns just after the accept edge.
  task automatic send(input logic we, input logic [4:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] ed, input logic ee);
    valid12   = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    q1.push_back('{due: cyc + 1, d: ed, e: ee});
    q2.push_back('{due: cyc + 2, d: ed, e: ee});
    @(posedge clk);
    #1;
  endtask

  task automatic readback();
    for (int a = 0; a < 16; a++) begin
      send(1'b0, 5'(a), 32'd0, 4'd0, model[a], 1'b0);
    end
    valid12 = 1'b0;
  endtask

  // Call at a falling edge inside the first cycle after the reset edge.
  task automatic clear_check(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bz1) break;
      n++;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, 32'(n), 32'd16);
    chk({nm, " ready1"}, {31'd0, rdy1}, 32'd1);
    chk({nm, " ready2"}, {31'd0, rdy2}, 32'd1);
    chk({nm, " busy2"}, {31'd0, bz2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 5'd3,  32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 5'd3,  32'h11223344, 4'h5, 32'h0,        1'b0};
    vt[2]  = '{1'b0, 5'd3,  32'h0,        4'h0, 32'hAA22CC44, 1'b0};
    vt[3]  = '{1'b1, 5'd7,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 5'd7,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[5]  = '{1'b1, 5'd20, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vt[6]  = '{1'b0, 5'd20, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 5'd9,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 5'd9,  32'h0,        4'h0, 32'h0,        1'b0};
    vt[9]  = '{1'b1, 5'd15, 32'h80000001, 4'hF, 32'h0,        1'b0};
    vt[10] = '{1'b0, 5'd15, 32'h0,        4'h0, 32'h80000001, 1'b0};
    vt[11] = '{1'b0, 5'd31, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[12] = '{1'b0, 5'd16, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[13] = '{1'b0, 5'd0,  32'h0,        4'h0, 32'h0,        1'b0};

    rst_n     = 1'b0;
    valid12   = 1'b0;
    valid3    = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid1", {31'd0, rv1}, 32'd0);
    chk("reset rsp_rdata1", rd1, 32'd0);
    chk("reset rsp_err1", {31'd0, re1}, 32'd0);
    chk("reset ready1", {31'd0, rdy1}, 32'd0);
    chk("reset busy1", {31'd0, bz1}, 32'd1);
    chk("reset rsp_valid2", {31'd0, rv2}, 32'd0);
    chk("reset busy3", {31'd0, bz3}, 32'd0);
    chk("reset ready3", {31'd0, rdy3}, 32'd0);
    rst_n = 1'b1;
    clear_check("initial clear");

    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    @(posedge clk);
    #1;
    readback();

    for (int i = 0; i < 14; i++) begin
      send(vt[i].we, vt[i].addr, vt[i].wd, vt[i].be, vt[i].ed, vt[i].ee);
    end
    valid12 = 1'b0;

    model[3]  = 32'hAA22CC44;
    model[7]  = 32'hDEADBEEF;
    model[15] = 32'h80000001;
    @(posedge clk);
    #1;
    readback();

    // Reset lands on the edge after the second of four reads is accepted.
    @(posedge clk);
    #1;
    send(1'b0, 5'd1, 32'd0, 4'd0, model[1], 1'b0);
    send(1'b0, 5'd2, 32'd0, 4'd0, model[2], 1'b0);
    rst_n    = 1'b0;
    valid12  = 1'b1;
    req_addr = 5'd3;
    while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
    while (q2.size() > 0 && q2[$].due > cyc) void'(q2.pop_back());
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    valid12 = 1'b0;
    @(negedge clk);
    clear_check("midstream clear");

    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    @(posedge clk);
    #1;
    readback();
    repeat (4) @(negedge clk);
    chk("queue1 drained", 32'(q1.size()), 32'd0);
    chk("queue2 drained", 32'(q2.size()), 32'd0);

    // Contents survive reset when the clear is disabled.
    @(posedge clk);
    #1;
    valid3    = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'd5;
    req_wdata = 32'h0000CAFE;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("nc write rsp_valid", {31'd0, rv3}, 32'd1);
    chk("nc write rdata", rd3, 32'd0);
    chk("nc write err", {31'd0, re3}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("nc reset ready", {31'd0, rdy3}, 32'd0);
    chk("nc reset rsp_valid", {31'd0, rv3}, 32'd0);
    chk("nc reset busy", {31'd0, bz3}, 32'd0);
    @(posedge clk);
    #1;
    valid3   = 1'b1;
    req_we   = 1'b0;
    req_addr = 5'd5;
    @(negedge clk);
    chk("nc ready after reset", {31'd0, rdy3}, 32'd1);
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(negedge clk);
    chk("nc read rsp_valid", {31'd0, rv3}, 32'd1);
    chk("nc read rdata", rd3, 32'h0000CAFE);
    chk("nc read err", {31'd0, re3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised single-port on-chip SRAM with a valid/ready request interface, byte-enable writes, configurable read latency, address range checking and a hardware background-clear sequencer. It replaces the fixed 1 MB/32-bit memory as the generic RAM block behind the system bus. Memory is zeroed by a counter-driven clear after reset, not by a reset-time loop.

## Interface
- DATA_W, 32: data width in bits, multiple of 8
- DEPTH, 262144: number of words
- ADDR_W, 18: word-address width; 2^ADDR_W >= DEPTH
- RD_LAT, 1: request-accept to response latency in cycles, legal values 1 or 2
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = contents preserved across reset

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables, bit i covers wdata[8i+7:8i]
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errored reads
- rsp_err  out  1  address >= DEPTH
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLEAR, RUN.
- Reset (rst_n low at a rising edge): state <= CLEAR if CLEAR_ON_RESET else RUN; clear counter <= 0; latency pipeline flushed. rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, busy=CLEAR_ON_RESET.
- CLEAR: each cycle writes all-zero to word clr_cnt, clr_cnt++. On clr_cnt == DEPTH-1, go to RUN. req_ready=0, busy=1. Requests are not accepted.
- RUN: req_ready=1 every cycle. No response backpressure.
- Accepted write, in range: bytes with req_be[i]=1 updated at the accept edge; other bytes unchanged. req_be=0 is a legal no-op. A response is produced with rsp_err=0 and rsp_rdata=0.
- Accepted read, in range: the response carries the word as it stood after all earlier accepted writes. A write followed immediately by a read to the same address returns the new data.
- Address >= DEPTH: a write is dropped and a read does not touch the array. The response has rsp_err=1 and rsp_rdata=0.
- Every accepted request produces exactly one response, in order.
- Reset mid-operation: in-flight responses are discarded, the clear restarts from word 0, and partial array state is irrelevant because it is overwritten.

## Timing
- Accept at edge N gives rsp_valid=1 during the cycle after edge N+RD_LAT-1.
  - RD_LAT=1: response registered at the accept edge, visible in the next cycle.
  - RD_LAT=2: one extra output register.
- Throughput is one request per cycle. Back-to-back requests give back-to-back responses.
- rsp_rdata and rsp_err are held at their last value when rsp_valid=0. The exception is reset, which forces 0.
- Clear timing: with rst_n high from edge E, clearing occupies edges E..E+DEPTH-1. busy=0 and req_ready=1 from the cycle after edge E+DEPTH-1.
- CLEAR_ON_RESET=0: req_ready=1 in the first cycle after rst_n goes high.

## Structure
- Package sram_pkg holds:
  - the state typedef (CLEAR, RUN);
  - the legal RD_LAT range constants;
  - an elaboration-time check function for DATA_W%8==0, 2^ADDR_W>=DEPTH and RD_LAT in 1..2.
- Sub-module sram_array is the raw storage: one write port with byte enables and one registered read, no reset on the array. It keeps a clean mapping to vendor RAM macros.
- sram_ctrl holds the FSM, clear counter, range check, write-data mux (clear vs request) and latency/valid pipeline.

## Test plan
Tests use DEPTH=16, ADDR_W=5, DATA_W=32.
- Clear: release rst_n. busy=1 for exactly 16 cycles, then req_ready=1. Reads of addresses 0..15 all return 0x00000000 with rsp_err=0.
- Byte enables: write 0xAABBCCDD, be=4'b1111, to addr 3. Then write 0x11223344, be=4'b0101, to addr 3. Read addr 3 -> 0xAA22CC44.
- Latency and forwarding, RD_LAT=1 and 2: write 0xDEADBEEF to addr 7, then read addr 7 on the next cycle. The read's rsp_valid arrives exactly RD_LAT cycles after its accept, with data 0xDEADBEEF. 8 back-to-back reads give 8 consecutive rsp_valid cycles.
- Range error: write 0x12345678 to addr 20, then read addr 20. Both responses have rsp_err=1 and rsp_rdata=0. Addresses 0..15 are unchanged.
- Reset mid-stream: issue reads to addrs 1..4 and assert rst_n low for one edge after the second accept. No further rsp_valid. The clear restarts: busy=1 for 16 cycles and all words read back 0.
- CLEAR_ON_RESET=0: write 0x0000CAFE to addr 5, pulse reset. req_ready=1 in the first cycle after reset and a read of addr 5 returns 0x0000CAFE.
